// File: rtl/complex_pkg.sv
// Shared types and helpers for the complex frame accumulator: product slicing,
// sign extension and the accumulator FSM state encoding.
package complex_pkg;

    localparam int OP_W   = 32;
    localparam int IN_W   = 65;
    localparam int PROD_W = 2 * IN_W;
    // OP_W bits of headroom above a sample cover any practical FRAME_LEN growth.
    localparam int SEXT_W = IN_W + OP_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [IN_W-1:0] get_real(input logic [PROD_W-1:0] prod);
        return prod[PROD_W-1:IN_W];
    endfunction

    function automatic logic [IN_W-1:0] get_imag(input logic [PROD_W-1:0] prod);
        return prod[IN_W-1:0];
    endfunction

    function automatic logic [SEXT_W-1:0] sext(input logic [IN_W-1:0] x);
        return {{OP_W{x[IN_W-1]}}, x};
    endfunction

endpackage

// File: rtl/complex_add_lane.sv
// One accumulator lane: adds a sign-extended IN_W sample to an ACC_W running sum.
// The real and imaginary lanes are independent instances of this adder.
module complex_add_lane #(
    parameter int IN_W  = 65,
    parameter int ACC_W = 68
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic signed [IN_W-1:0]  sample_i,
    output logic signed [ACC_W-1:0] sum_o
);
    import complex_pkg::*;

    logic [SEXT_W-1:0] ext_s;

    assign ext_s = sext(sample_i);
    assign sum_o = acc_i + $signed(ext_s[ACC_W-1:0]);

endmodule

// File: rtl/complex_acc.sv
// Frame accumulator: sums FRAME_LEN accepted complex products, then presents the
// frame sum on a valid/ready handshake and holds it until taken or flushed.
module complex_acc #(
    parameter int FRAME_LEN = 8,
    parameter int IN_W      = 65,
    parameter int ACC_W     = IN_W + $clog2(FRAME_LEN)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [2*IN_W-1:0]                  result,
    input  logic                               flush,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [ACC_W-1:0]            out_real,
    output logic signed [ACC_W-1:0]            out_imag,
    output logic [$clog2(FRAME_LEN+1)-1:0]     frame_cnt
);
    import complex_pkg::*;

    localparam int              CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic signed [ACC_W-1:0] sum_re_s, sum_im_s;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    accept_s;

    // The accumulators are zero in IDLE, so the same adder also loads the first sample.
    complex_add_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane_re (
        .acc_i    (acc_re_q),
        .sample_i (get_real(result)),
        .sum_o    (sum_re_s)
    );

    complex_add_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane_im (
        .acc_i    (acc_im_q),
        .sample_i (get_imag(result)),
        .sum_o    (sum_im_s)
    );

    assign accept_s = in_valid && in_ready_q;

    // Next-state, accumulator, counter and handshake-output computation.
    always_comb begin
        state_d     = state_q;
        acc_re_d    = acc_re_q;
        acc_im_d    = acc_im_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            state_d     = IDLE;
            acc_re_d    = {ACC_W{1'b0}};
            acc_im_d    = {ACC_W{1'b0}};
            cnt_d       = {CNT_W{1'b0}};
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACC: begin
                    if (accept_s) begin
                        acc_re_d = sum_re_s;
                        acc_im_d = sum_im_s;
                        cnt_d    = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            state_d     = DONE;
                            in_ready_d  = 1'b0;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d = ACC;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d     = IDLE;
                        acc_re_d    = {ACC_W{1'b0}};
                        acc_im_d    = {ACC_W{1'b0}};
                        cnt_d       = {CNT_W{1'b0}};
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    acc_re_d    = {ACC_W{1'b0}};
                    acc_im_d    = {ACC_W{1'b0}};
                    cnt_d       = {CNT_W{1'b0}};
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // FSM state, accumulators, counter and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_re_q    <= {ACC_W{1'b0}};
            acc_im_q    <= {ACC_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_re_q    <= acc_re_d;
            acc_im_q    <= acc_im_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_real  = acc_re_q;
    assign out_imag  = acc_im_q;
    assign frame_cnt = cnt_q;

endmodule
